md_iter: RTL and testbench
==========================

MD_ITER -- requirements
Module: md_iter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand and HI/LO width (>= 8, even).
REQ-002 The block SHALL have parameter MUL_LAT, default 5, busy cycles for multiply-class ops (1..15).
REQ-003 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port md_op  input  4  op code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 maddu, 11 msub, 12 msubu, 13-15 none.
REQ-006 The block SHALL have port rs  input  WIDTH  first operand / mthi-mtlo source.
REQ-007 The block SHALL have port rt  input  WIDTH  second operand.
REQ-008 The block SHALL have port cancel  input  1  exception flush, aborts the issuing or in-flight op.
REQ-009 The block SHALL have port start  output  1  combinational, high when md_op is a multi-cycle op (1-4, 9-12).
REQ-010 The block SHALL have port busy  output  1  registered, high while an op is in flight.
REQ-011 The block SHALL have port hi  output  WIDTH  HI register.
REQ-012 The block SHALL have port lo  output  WIDTH  LO register.
REQ-013 The block SHALL have port md_out  output  WIDTH  combinational: hi for mfhi, lo for mflo, else 0.

Function
REQ-014 The block SHALL use FSM states IDLE, MUL, DIV, FIX; it SHALL accept an op only in IDLE with busy low and cancel low; the issuer stalls all md_op != 0 while busy, and ops presented while busy SHALL be ignored.
REQ-015 An op accepted in cycle T SHALL latch md_op, rs, rt at the edge ending T; busy SHALL be high cycles T+1..T+N; hi/lo SHALL update at the edge ending T+N; busy SHALL be low in T+N+1.
REQ-016 N SHALL be MUL_LAT for ops 1, 2, 9-12, and WIDTH+1 for ops 3, 4 (WIDTH radix-2 restoring iterations in DIV, then one sign-fixup cycle in FIX).
REQ-017 mult/multu SHALL write the 2*WIDTH signed/unsigned product to {hi,lo}.
REQ-018 madd/maddu/msub/msubu SHALL write {hi,lo} +/- product, using the {hi,lo} value current at the final edge, modulo 2^(2*WIDTH).
REQ-019 div/divu SHALL write quotient to lo and remainder to hi; quotient truncates toward zero, and the remainder takes the sign of the dividend.
REQ-020 Divide by zero SHALL give lo = all ones and hi = rs, for both signed and unsigned.
REQ-021 Signed div of most-negative by -1 SHALL give lo = most-negative and hi = 0.
REQ-022 mthi/mtlo SHALL write rs to hi/lo at the end of the issuing cycle, with busy staying low; they SHALL be suppressed when cancel is high.
REQ-023 cancel in an accepted cycle SHALL prevent the op from starting; cancel while busy SHALL abort the op to IDLE at the next edge, leave hi/lo unchanged, and drive busy low the next cycle.
REQ-024 md_out SHALL reflect the current registered hi/lo, including while busy.

Reset
REQ-025 Reset SHALL put the FSM in IDLE; busy, hi, lo, the latched op/operands, and the iteration counter SHALL all be 0; reset SHALL take priority over all inputs.
REQ-026 Reset mid-operation SHALL discard the op and leave busy low in the following cycle.

Structure
REQ-027 Package md_pkg SHALL hold the md_op code constants, the FSM state encoding, and a function returning N for an op.
REQ-028 The divide datapath SHALL be a sub-module md_div_iter (unsigned restoring core with load, step, and done signals); sign handling SHALL live in md_iter.

Verification
REQ-029 The bench SHALL drive mult rs=FFFFFFFF, rt=00000002 and require, after 5 busy cycles, hi=FFFFFFFF and lo=FFFFFFFE; the same operands with multu SHALL give hi=00000001 and lo=FFFFFFFE.
REQ-030 The bench SHALL drive div rs=FFFFFFF9 (-7), rt=2 and require 33 busy cycles, then lo=FFFFFFFD and hi=FFFFFFFF; divu rs=7, rt=0 SHALL give lo=FFFFFFFF and hi=7.
REQ-031 The bench SHALL apply mtlo 5 and mthi 0, then madd 3,4, and require lo=00000011 and hi=0; a following msubu 1,00000012 SHALL give {hi,lo}=FFFFFFFF_FFFFFFFF.
REQ-032 The bench SHALL issue div, assert cancel in busy cycle 10, and require busy low next cycle with hi/lo unchanged; mthi issued with cancel high SHALL leave hi unchanged.
REQ-033 The bench SHALL issue mult, then assert reset in busy cycle 3, and require busy=0, hi=0 and lo=0; the bench SHALL also require that mflo presented while busy returns the old lo and has no effect.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - md_op code constants
//   - FSM state encoding
//   - helpers classifying an op and returning its busy-cycle count N
package md_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_t;

    function automatic logic md_is_mul(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
               (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    function automatic logic md_is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Busy cycles for an op: MUL_LAT for multiply class, WIDTH iterations
    // plus one sign-fixup cycle for divides, zero for everything else.
    function automatic int unsigned md_cycles(input logic [3:0] op,
                                              input int unsigned width,
                                              input int unsigned mul_lat);
        if (md_is_mul(op))
            return mul_lat;
        else if (md_is_div(op))
            return width + 1;
        else
            return 0;
    endfunction

endpackage

// File: rtl/md_div_iter.sv
// Unsigned radix-2 restoring divider core, one quotient bit per step.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   load                capture dividend/divisor and clear the step count
//   step                perform one restoring iteration
//   dividend, divisor   unsigned operands (sampled on load)
//   quotient, remainder results, valid after WIDTH steps
//   done                high while the current step is the final one
module md_div_iter
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;

    // Dividend bits shift out of quo_q into the partial remainder while
    // quotient bits shift in from the bottom. With a nonzero divisor the
    // partial remainder stays below the divisor, so diff[WIDTH] is a clean
    // borrow flag.
    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, dvs_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            quo_q <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
            cnt_q <= '0;
        end else if (step) begin
            if (!diff[WIDTH]) begin
                rem_q <= diff[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_q <= rem_sh[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign done      = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/md_iter.sv
// Iterative multiply/divide unit with HI/LO registers.
// Ports:
//   clk, reset   clock, synchronous active-high reset (highest priority)
//   md_op        op code (see md_pkg)
//   rs, rt       operands; rs is also the mthi/mtlo source
//   cancel       flush: blocks an issuing op, aborts an in-flight one
//   start        combinational, md_op is a multi-cycle op
//   busy         registered, an op is in flight
//   hi, lo       HI/LO registers
//   md_out       combinational mfhi/mflo read port
module md_iter
    import md_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       md_op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             cancel,
    output logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] md_out
);

    md_state_t        state_q, state_d;
    logic             busy_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] rs_q, rt_q;
    logic [3:0]       cnt_q;

    logic accept, wr_mul, wr_div, wr_hi, wr_lo, div_load, div_step, div_done;
    logic [WIDTH-1:0] div_quo, div_rem;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign start  = md_is_mul(md_op) || md_is_div(md_op);
    assign busy   = busy_q;
    assign md_out = (md_op == OP_MFHI) ? hi : ((md_op == OP_MFLO) ? lo : '0);

    // Divider operands are converted to magnitudes on the issuing cycle.
    logic             sdiv_in;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    assign sdiv_in = (md_op == OP_DIV);
    assign dvd_mag = cond_neg(rs, sdiv_in && rs[WIDTH-1]);
    assign dvs_mag = cond_neg(rt, sdiv_in && rt[WIDTH-1]);

    md_div_iter #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .load      (div_load),
        .step      (div_step),
        .dividend  (dvd_mag),
        .divisor   (dvs_mag),
        .quotient  (div_quo),
        .remainder (div_rem),
        .done      (div_done)
    );

    // Extending to 2*WIDTH before multiplying makes one multiplier serve
    // both signednesses; only the low 2*WIDTH bits are kept.
    logic                 smul;
    logic [2*WIDTH-1:0]   a_ext, b_ext, prod, acc, mul_res;
    assign smul  = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
    assign a_ext = {{WIDTH{smul & rs_q[WIDTH-1]}}, rs_q};
    assign b_ext = {{WIDTH{smul & rt_q[WIDTH-1]}}, rt_q};
    assign prod  = a_ext * b_ext;
    assign acc   = {hi, lo};

    always_comb begin
        mul_res = prod;
        if ((op_q == OP_MADD) || (op_q == OP_MADDU))
            mul_res = acc + prod;
        else if ((op_q == OP_MSUB) || (op_q == OP_MSUBU))
            mul_res = acc - prod;
    end

    // Sign fixup; divide-by-zero is special-cased, most-negative / -1 falls
    // out naturally because the magnitude quotient wraps back to itself.
    logic             sdiv_q;
    logic [WIDTH-1:0] fix_lo, fix_hi;
    assign sdiv_q = (op_q == OP_DIV);
    always_comb begin
        fix_lo = cond_neg(div_quo, sdiv_q && (rs_q[WIDTH-1] ^ rt_q[WIDTH-1]));
        fix_hi = cond_neg(div_rem, sdiv_q && rs_q[WIDTH-1]);
        if (rt_q == '0) begin
            fix_lo = '1;
            fix_hi = rs_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        wr_mul   = 1'b0;
        wr_div   = 1'b0;
        wr_hi    = 1'b0;
        wr_lo    = 1'b0;
        div_load = 1'b0;
        div_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!cancel) begin
                    wr_hi = (md_op == OP_MTHI);
                    wr_lo = (md_op == OP_MTLO);
                    if (start) begin
                        accept   = 1'b1;
                        div_load = md_is_div(md_op);
                        state_d  = md_is_div(md_op) ? ST_DIV : ST_MUL;
                    end
                end
            end
            ST_MUL: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd0) begin
                    wr_mul  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    div_step = 1'b1;
                    if (div_done)
                        state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                wr_div  = !cancel;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q  <= '0;
            rs_q  <= '0;
            rt_q  <= '0;
            cnt_q <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            if (accept) begin
                op_q  <= md_op;
                rs_q  <= rs;
                rt_q  <= rt;
                cnt_q <= md_is_mul(md_op) ?
                         4'(md_cycles(md_op, WIDTH, MUL_LAT) - 1) : 4'd0;
            end else if ((state_q == ST_MUL) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (wr_mul) begin
                hi <= mul_res[2*WIDTH-1:WIDTH];
                lo <= mul_res[WIDTH-1:0];
            end
            if (wr_div) begin
                hi <= fix_hi;
                lo <= fix_lo;
            end
            if (wr_hi)
                hi <= rs;
            if (wr_lo)
                lo <= rs;
        end
    end

endmodule

// File: tb/tb_md_iter.sv
module tb_md_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cancel;
    logic [3:0]  md_op;
    logic [31:0] rs, rt;
    logic        start, busy;
    logic [31:0] hi, lo, md_out;

    int checks = 0;
    int passes = 0;
    logic [31:0] m_hi, m_lo;

    always #5 clk = ~clk;

    md_iter #(.WIDTH(32), .MUL_LAT(5)) dut (
        .clk(clk), .reset(reset), .md_op(md_op), .rs(rs), .rt(rt),
        .cancel(cancel), .start(start), .busy(busy), .hi(hi), .lo(lo),
        .md_out(md_out)
    );

    function automatic int exp_cycles(input logic [3:0] op);
        case (op)
            4'd1, 4'd2, 4'd9, 4'd10, 4'd11, 4'd12: return 5;
            4'd3, 4'd4: return 33;
            default: return 0;
        endcase
    endfunction

    // Architectural reference: 64-bit integer arithmetic on HI:LO.
    function automatic void model_apply(input logic [3:0] op,
                                        input logic [31:0] a, input logic [31:0] b);
        logic [63:0] acc, p;
        acc = {m_hi, m_lo};
        if (op == 4'd1 || op == 4'd9 || op == 4'd11)
            p = 64'(longint'(int'(a)) * longint'(int'(b)));
        else
            p = {32'd0, a} * {32'd0, b};
        case (op)
            4'd1, 4'd2: {m_hi, m_lo} = p;
            4'd9, 4'd10: {m_hi, m_lo} = acc + p;
            4'd11, 4'd12: {m_hi, m_lo} = acc - p;
            4'd3: begin
                if (b == 0) begin m_lo = '1; m_hi = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_lo = a; m_hi = 0; end
                else begin m_lo = 32'(int'(a) / int'(b)); m_hi = 32'(int'(a) % int'(b)); end
            end
            4'd4: begin
                if (b == 0) begin m_lo = '1; m_hi = a; end
                else begin m_lo = a / b; m_hi = a % b; end
            end
            4'd7: m_hi = a;
            4'd8: m_lo = a;
            default: ;
        endcase
    endfunction

    // Issue one op and count the busy cycles that follow (bounded).
    task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int n);
        @(negedge clk); md_op = op; rs = a; rt = b;
        @(negedge clk); md_op = 4'd0; rs = '0; rt = '0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
    endtask

    task automatic test_reset();
        reset = 1'b1; cancel = 1'b0; md_op = 4'd0; rs = '0; rt = '0;
        repeat (2) @(negedge clk);
        md_op = 4'd7; rs = 32'hAAAA_5555;
        @(negedge clk);
        md_op = 4'd5; #1;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
        checks++; if (hi !== 32'h0) $display("FAIL reset_hi: got %h want 0", hi); else passes++;
        checks++; if (lo !== 32'h0) $display("FAIL reset_lo: got %h want 0", lo); else passes++;
        checks++; if (md_out !== 32'h0) $display("FAIL reset_mdout: got %h want 0", md_out); else passes++;
        md_op = 4'd3; #1;
        checks++; if (start !== 1'b1) $display("FAIL start_div: got %b want 1", start); else passes++;
        md_op = 4'd8; #1;
        checks++; if (start !== 1'b0) $display("FAIL start_mtlo: got %b want 0", start); else passes++;
        md_op = 4'd0; rs = '0;
        @(negedge clk); reset = 1'b0;
        m_hi = 0; m_lo = 0;
    endtask

    task automatic test_mult();
        int n;
        run_op(4'd1, 32'hFFFF_FFFF, 32'h2, n); model_apply(4'd1, 32'hFFFF_FFFF, 32'h2);
        checks++; if (n != 5) $display("FAIL mult_cycles: got %0d want 5", n); else passes++;
        checks++; if (hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi: got %h want FFFFFFFF", hi); else passes++;
        checks++; if (lo !== 32'hFFFF_FFFE) $display("FAIL mult_lo: got %h want FFFFFFFE", lo); else passes++;
        run_op(4'd2, 32'hFFFF_FFFF, 32'h2, n); model_apply(4'd2, 32'hFFFF_FFFF, 32'h2);
        checks++; if (hi !== 32'h1) $display("FAIL multu_hi: got %h want 00000001", hi); else passes++;
        checks++; if (lo !== 32'hFFFF_FFFE) $display("FAIL multu_lo: got %h want FFFFFFFE", lo); else passes++;
    endtask

    task automatic test_div();
        int n;
        run_op(4'd3, 32'hFFFF_FFF9, 32'h2, n); model_apply(4'd3, 32'hFFFF_FFF9, 32'h2);
        checks++; if (n != 33) $display("FAIL div_cycles: got %0d want 33", n); else passes++;
        checks++; if (lo !== 32'hFFFF_FFFD) $display("FAIL div_lo: got %h want FFFFFFFD", lo); else passes++;
        checks++; if (hi !== 32'hFFFF_FFFF) $display("FAIL div_hi: got %h want FFFFFFFF", hi); else passes++;
        run_op(4'd4, 32'h7, 32'h0, n); model_apply(4'd4, 32'h7, 32'h0);
        checks++; if (lo !== 32'hFFFF_FFFF) $display("FAIL divu0_lo: got %h want FFFFFFFF", lo); else passes++;
        checks++; if (hi !== 32'h7) $display("FAIL divu0_hi: got %h want 00000007", hi); else passes++;
        run_op(4'd3, 32'hFFFF_FFF9, 32'h0, n); model_apply(4'd3, 32'hFFFF_FFF9, 32'h0);
        checks++; if (lo !== 32'hFFFF_FFFF) $display("FAIL div0_lo: got %h want FFFFFFFF", lo); else passes++;
        checks++; if (hi !== 32'hFFFF_FFF9) $display("FAIL div0_hi: got %h want FFFFFFF9", hi); else passes++;
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, n); model_apply(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        checks++; if (lo !== 32'h8000_0000) $display("FAIL divovf_lo: got %h want 80000000", lo); else passes++;
        checks++; if (hi !== 32'h0) $display("FAIL divovf_hi: got %h want 0", hi); else passes++;
    endtask

    task automatic test_madd();
        int n;
        run_op(4'd8, 32'h5, 32'h0, n); model_apply(4'd8, 32'h5, 32'h0);
        checks++; if (n != 0) $display("FAIL mtlo_busy: got %0d busy cycles want 0", n); else passes++;
        checks++; if (lo !== 32'h5) $display("FAIL mtlo_lo: got %h want 00000005", lo); else passes++;
        run_op(4'd7, 32'h0, 32'h0, n); model_apply(4'd7, 32'h0, 32'h0);
        run_op(4'd9, 32'h3, 32'h4, n); model_apply(4'd9, 32'h3, 32'h4);
        checks++; if (lo !== 32'h11) $display("FAIL madd_lo: got %h want 00000011", lo); else passes++;
        checks++; if (hi !== 32'h0) $display("FAIL madd_hi: got %h want 0", hi); else passes++;
        run_op(4'd12, 32'h1, 32'h12, n); model_apply(4'd12, 32'h1, 32'h12);
        checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL msubu: got %h_%h want FFFFFFFF_FFFFFFFF", hi, lo); else passes++;
    endtask

    task automatic test_cancel();
        @(negedge clk); md_op = 4'd3; rs = 32'd100; rt = 32'd7;
        @(negedge clk); md_op = 4'd0;
        repeat (9) @(negedge clk);
        checks++; if (busy !== 1'b1) $display("FAIL cancel_pre_busy: got %b want 1", busy); else passes++;
        cancel = 1'b1;
        @(negedge clk); cancel = 1'b0;
        checks++; if (busy !== 1'b0) $display("FAIL cancel_busy: got %b want 0", busy); else passes++;
        checks++; if ({hi, lo} !== {m_hi, m_lo}) $display("FAIL cancel_hilo: got %h_%h want %h_%h", hi, lo, m_hi, m_lo); else passes++;
        @(negedge clk);
        checks++; if ({hi, lo} !== {m_hi, m_lo}) $display("FAIL cancel_hilo_late: got %h_%h want %h_%h", hi, lo, m_hi, m_lo); else passes++;
        md_op = 4'd7; rs = 32'hCAFE_F00D; cancel = 1'b1;
        @(negedge clk); md_op = 4'd0; cancel = 1'b0;
        checks++; if (hi !== m_hi) $display("FAIL mthi_cancel: got %h want %h", hi, m_hi); else passes++;
        md_op = 4'd1; rs = 32'd9; rt = 32'd9; cancel = 1'b1;
        @(negedge clk); md_op = 4'd0; cancel = 1'b0;
        checks++; if (busy !== 1'b0) $display("FAIL issue_cancel: got busy %b want 0", busy); else passes++;
    endtask

    task automatic test_mflo_busy();
        int n;
        run_op(4'd8, 32'h1234, 32'h0, n); model_apply(4'd8, 32'h1234, 32'h0);
        run_op(4'd7, 32'h0, 32'h0, n); model_apply(4'd7, 32'h0, 32'h0);
        @(negedge clk); md_op = 4'd1; rs = 32'd3; rt = 32'd5;
        @(negedge clk); md_op = 4'd6; rs = 32'hDEAD_BEEF; #1;
        checks++; if (md_out !== 32'h1234) $display("FAIL mflo_busy: got %h want 00001234", md_out); else passes++;
        @(negedge clk); md_op = 4'd0; rs = '0;
        n = 1;
        while (busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
        model_apply(4'd1, 32'd3, 32'd5);
        checks++; if (n != 5) $display("FAIL mflo_mult_cycles: got %0d want 5", n); else passes++;
        checks++; if ({hi, lo} !== {m_hi, m_lo}) $display("FAIL mflo_mult_res: got %h_%h want %h_%h", hi, lo, m_hi, m_lo); else passes++;
    endtask

    task automatic test_reset_mid();
        int n;
        run_op(4'd8, 32'h55, 32'h0, n);
        @(negedge clk); md_op = 4'd1; rs = 32'hFFFF_FFFF; rt = 32'd3;
        @(negedge clk); md_op = 4'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        m_hi = 0; m_lo = 0;
        checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else passes++;
        checks++; if (hi !== 32'h0) $display("FAIL rstmid_hi: got %h want 0", hi); else passes++;
        checks++; if (lo !== 32'h0) $display("FAIL rstmid_lo: got %h want 0", lo); else passes++;
        repeat (6) @(negedge clk);
        checks++; if ({hi, lo} !== 64'h0) $display("FAIL rstmid_late: got %h_%h want 0", hi, lo); else passes++;
    endtask

    task automatic test_random();
        logic [3:0] ops [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12};
        logic [3:0]  op;
        logic [31:0] a, b;
        int n;
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 9)];
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            if ($urandom_range(0, 7) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
            run_op(op, a, b, n);
            model_apply(op, a, b);
            checks++; if (n != exp_cycles(op)) $display("FAIL rnd%0d_cycles op=%0d: got %0d want %0d", i, op, n, exp_cycles(op)); else passes++;
            checks++; if ({hi, lo} !== {m_hi, m_lo}) $display("FAIL rnd%0d_hilo op=%0d a=%h b=%h: got %h_%h want %h_%h", i, op, a, b, hi, lo, m_hi, m_lo); else passes++;
            md_op = 4'd5; #1;
            checks++; if (md_out !== m_hi) $display("FAIL rnd%0d_mfhi: got %h want %h", i, md_out, m_hi); else passes++;
            md_op = 4'd0;
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_madd();
        test_cancel();
        test_mflo_busy();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
